fib_uart_ctrl: RTL

Command controller that sequences the UART block's FIFO interface to serve Fibonacci requests.
- Request: one RX byte `n`.
- Response: a framed reply on the TX FIFO. Either a status byte 0x00 followed by F(n) as W/8 bytes, MSB first, or the single error byte 0xEE.
- Sits between the UART's `rd_uart/rx_empty/r_data` and `wr_uart/tx_full/w_data` ports and an iterative Fibonacci datapath.
- Handles exactly one request at a time.

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_core.sv | 63 ++++++
 rtl/fib_uart_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci UART command controller:
// FSM state encoding, reply framing bytes and default sizing.
package fib_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    localparam logic [7:0] OK_BYTE  = 8'h00;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int          DEFAULT_W     = 32;
    localparam int unsigned DEFAULT_N_MAX = 47;

endpackage

// File: rtl/fib_core.sv
// Iterative Fibonacci datapath: after start_i with n_i it steps
// a<=b, b<=a+b once per cycle until the countdown reaches zero, then
// raises done_o for one cycle with F(n) on result_o.
module fib_core
    import fib_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [7:0]   n_i,
    output logic         done_o,
    output logic [W-1:0] result_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         run_q, run_d;

    // Next-state: load on start, otherwise step while running; b may wrap
    // on the final step, which never reaches the result.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            a_d   = '0;
            b_d   = W'(1);
            cnt_d = n_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == 8'd0) begin
                run_d = 1'b0;
            end else begin
                a_d   = b_q;
                b_d   = a_q + b_q;
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o   = run_q && (cnt_q == 8'd0);
    assign result_o = a_q;

endmodule

// File: rtl/fib_uart_ctrl.sv
// Fibonacci request controller between the UART FIFO ports and fib_core.
// Pops one request byte n, then writes either 0x00 + F(n) MSB first or
// the single error byte 0xEE. One request is served at a time.
module fib_uart_ctrl
    import fib_pkg::*;
#(
    parameter int          W     = DEFAULT_W,
    parameter int unsigned N_MAX = DEFAULT_N_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       done_tick
);

    localparam int BYTES = W / 8;
    localparam int IDX_W = $clog2(BYTES + 1);
    localparam logic [IDX_W-1:0] IDX_HDR = IDX_W'(BYTES);

    state_t           state_q, state_d;
    logic [W-1:0]     result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             accept;
    logic             core_start;
    logic             core_done;
    logic [W-1:0]     core_result;
    logic [W-1:0]     result_shift;

    assign accept     = (32'(r_data) <= N_MAX);
    // FIFO strobes are gated by reset so nothing is pushed or popped during it.
    assign rd_uart    = !reset && (state_q == ST_IDLE) && !rx_empty;
    assign wr_uart    = !reset && ((state_q == ST_SEND) || (state_q == ST_ERR)) && !tx_full;
    assign core_start = rd_uart && accept;
    assign busy       = (state_q != ST_IDLE);
    assign done_tick  = wr_uart && ((state_q == ST_ERR) || (idx_q == '0));

    assign result_shift = result_q >> (8 * idx_q);

    fib_core #(.W(W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .start_i  (core_start),
        .n_i      (r_data),
        .done_o   (core_done),
        .result_o (core_result)
    );

    // TX byte select: header, then result bytes MSB first; zero when idle.
    always_comb begin
        w_data = 8'h00;
        if (wr_uart) begin
            if (state_q == ST_ERR)
                w_data = ERR_BYTE;
            else if (idx_q == IDX_HDR)
                w_data = OK_BYTE;
            else
                w_data = result_shift[7:0];
        end
    end

    // Controller next-state: accept/reject request, wait for core, serialize.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_uart)
                    state_d = accept ? ST_CALC : ST_ERR;
            end
            ST_CALC: begin
                if (core_done) begin
                    result_d = core_result;
                    idx_d    = IDX_HDR;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (wr_uart) begin
                    idx_d = idx_q - 1'b1;
                    if (idx_q == '0)
                        state_d = ST_IDLE;
                end
            end
            default: begin
                if (wr_uart)
                    state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

endmodule
